// File: rtl/audio_mix_pkg.sv
// Shared types and sizing helpers for the stereo audio mixer.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } state_t;

  localparam int CLIP_CNT_W = 16;

  // Enough headroom that summing num_ch full-scale products can never wrap.
  function automatic int acc_width(input int in_w, input int gain_w, input int num_ch);
    return in_w + gain_w + $clog2(num_ch) - 1 + 1;
  endfunction

endpackage

// File: rtl/audio_mix_sat.sv
// Combinational saturator: clamps one accumulator side to OUT_W bits and flags clipping.
module audio_mix_sat #(
  parameter int ACC_W = 26,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] sat,
  output logic             clipped
);

  generate
    if (ACC_W > OUT_W) begin : g_clip
      assign clipped = |acc[ACC_W-1:OUT_W];
      assign sat     = clipped ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
    end else begin : g_fit
      assign clipped = 1'b0;
      assign sat     = OUT_W'(acc);
    end
  endgenerate

endmodule

// File: rtl/audio_mix.sv
// Time-multiplexed stereo mixer: snapshot on ce_sample, one channel MAC per cycle, saturate, registered output.
// Optional saturating clip counter built when AUDIO_MIX_CLIP_CNT_EN is defined.
module audio_mix
  import audio_mix_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int GAIN_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic                          clk_sys,
  input  logic                          rst,
  input  logic                          ce_sample,
  input  logic [NUM_CH-1:0][IN_W-1:0]   ch_in,
  input  logic [NUM_CH-1:0][GAIN_W-1:0] ch_gain,
  input  logic [NUM_CH-1:0]             ch_en_l,
  input  logic [NUM_CH-1:0]             ch_en_r,
  output logic [OUT_W-1:0]              out_l,
  output logic [OUT_W-1:0]              out_r,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          clip,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [CLIP_CNT_W-1:0]         clip_cnt,
  input  logic                          clip_cnt_clr
);

  localparam int ACC_W = acc_width(IN_W, GAIN_W, NUM_CH);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

  state_t state, state_nxt;
  logic [IDX_W-1:0]              idx;
  logic [NUM_CH-1:0][IN_W-1:0]   snap_in;
  logic [NUM_CH-1:0][GAIN_W-1:0] snap_gain;
  logic [NUM_CH-1:0]             snap_en_l, snap_en_r;
  logic [ACC_W-1:0]              acc_l, acc_r, term;
  logic [OUT_W-1:0]              sat_l, sat_r;
  logic                          clip_l, clip_r;
  logic                          start;

  assign start = (state == IDLE) && ce_sample;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk_sys) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ce_sample) state_nxt = ACCUM;
      ACCUM:   if (idx == LAST) state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Computed at accumulator width so the truncating shift discards no live bits.
  assign term = (ACC_W'(snap_in[idx]) * ACC_W'(snap_gain[idx])) >> (GAIN_W - 1);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      idx       <= '0;
      snap_in   <= '0;
      snap_gain <= '0;
      snap_en_l <= '0;
      snap_en_r <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_l     <= '0;
      out_r     <= '0;
      clip      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (start) begin
        snap_in   <= ch_in;
        snap_gain <= ch_gain;
        snap_en_l <= ch_en_l;
        snap_en_r <= ch_en_r;
        acc_l     <= '0;
        acc_r     <= '0;
        idx       <= '0;
      end
      if (state == ACCUM) begin
        acc_l <= acc_l + (snap_en_l[idx] ? term : '0);
        acc_r <= acc_r + (snap_en_r[idx] ? term : '0);
        if (idx != LAST) idx <= idx + 1'b1;
      end
      if (state == SAT) begin
        out_l     <= sat_l;
        out_r     <= sat_r;
        clip      <= clip_l | clip_r;
        out_valid <= 1'b1;
      end
      // A dropped strobe outranks a same-cycle clear.
      if (ce_sample && busy) overrun <= 1'b1;
      else if (overrun_clr)  overrun <= 1'b0;
    end
  end

  audio_mix_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_l (
    .acc(acc_l), .sat(sat_l), .clipped(clip_l)
  );

  audio_mix_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_r (
    .acc(acc_r), .sat(sat_r), .clipped(clip_r)
  );

`ifdef AUDIO_MIX_CLIP_CNT_EN
  logic [CLIP_CNT_W-1:0] clip_cnt_q;

  always_ff @(posedge clk_sys) begin
    if (rst || clip_cnt_clr)
      clip_cnt_q <= '0;
    else if (out_valid && clip && (clip_cnt_q != {CLIP_CNT_W{1'b1}}))
      clip_cnt_q <= clip_cnt_q + 1'b1;
  end

  assign clip_cnt = clip_cnt_q;
`else
  logic unused_clip_cnt_clr;

  assign clip_cnt            = '0;
  assign unused_clip_cnt_clr = clip_cnt_clr;
`endif

endmodule

// File: tb/tb_audio_mix.sv
// Directed bench for audio_mix: arithmetic reference model checked every cycle plus literal spot checks.
module tb_audio_mix;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 16;
  localparam int GAIN_W = 8;
  localparam int OUT_W  = 16;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic                          rst = 1'b1;
  logic                          ce_sample = 1'b0;
  logic [NUM_CH-1:0][IN_W-1:0]   ch_in = '0;
  logic [NUM_CH-1:0][GAIN_W-1:0] ch_gain = '0;
  logic [NUM_CH-1:0]             ch_en_l = '0;
  logic [NUM_CH-1:0]             ch_en_r = '0;
  logic [OUT_W-1:0]              out_l, out_r;
  logic                          out_valid, busy, clip, overrun;
  logic                          overrun_clr = 1'b0;
  logic [15:0]                   clip_cnt;
  logic                          clip_cnt_clr = 1'b0;

  audio_mix #(.NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) dut (
    .clk_sys(clk_sys), .rst(rst), .ce_sample(ce_sample),
    .ch_in(ch_in), .ch_gain(ch_gain), .ch_en_l(ch_en_l), .ch_en_r(ch_en_r),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .busy(busy),
    .clip(clip), .overrun(overrun), .overrun_clr(overrun_clr),
    .clip_cnt(clip_cnt), .clip_cnt_clr(clip_cnt_clr)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference mix straight from the arithmetic definition, on the inputs seen at the strobe.
  function automatic void mix_model(output logic [15:0] l, output logic [15:0] r, output logic c);
    longint sl, sr, p;
    sl = 0;
    sr = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      p = (longint'(ch_in[i]) * longint'(ch_gain[i])) / (longint'(1) << (GAIN_W - 1));
      if (ch_en_l[i]) sl += p;
      if (ch_en_r[i]) sr += p;
    end
    l = (sl > 65535) ? 16'hFFFF : 16'(sl);
    r = (sr > 65535) ? 16'hFFFF : 16'(sr);
    c = (sl > 65535) || (sr > 65535);
  endfunction

  // Model: cycles left until idle, pending result, and what the outputs show now.
  int          m_busy = 0;
  logic        m_valid = 1'b0, m_clip = 1'b0, m_over = 1'b0, p_clip = 1'b0;
  logic [15:0] m_l = '0, m_r = '0, p_l = '0, p_r = '0, m_cnt = '0;
  logic        sat_now;

  always @(negedge clk_sys) begin
    if (cyc >= 1) begin
      chk("out_valid", out_valid, m_valid);
      chk("out_l", out_l, m_l);
      chk("out_r", out_r, m_r);
      chk("clip", clip, m_clip);
      chk("busy", busy, m_busy != 0);
      chk("overrun", overrun, m_over);
      chk("clip_cnt", clip_cnt, m_cnt);
    end
    if (rst) begin
      m_busy = 0; m_valid = 0; m_clip = 0; m_over = 0;
      m_l = '0; m_r = '0; m_cnt = '0;
    end else begin
`ifdef AUDIO_MIX_CLIP_CNT_EN
      if (clip_cnt_clr) m_cnt = '0;
      else if (m_valid && m_clip && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
`endif
      sat_now = (m_busy == 1);
      if (sat_now) begin
        m_l = p_l; m_r = p_r; m_clip = p_clip;
      end
      if (ce_sample && m_busy > 0) m_over = 1'b1;
      else if (overrun_clr)        m_over = 1'b0;
      if (ce_sample && m_busy == 0) begin
        mix_model(p_l, p_r, p_clip);
        m_busy = NUM_CH + 1;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      m_valid = sat_now;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic set_ch(input int i, input logic [15:0] v, input logic [7:0] g,
                        input logic el, input logic er);
    ch_in[i] = v; ch_gain[i] = g; ch_en_l[i] = el; ch_en_r[i] = er;
  endtask

  // Strobe now (cycle T); check out_valid low at T+5 and the result at T+6.
  task automatic run_mix(input string name, input logic [15:0] el, input logic [15:0] er,
                         input logic ec);
    ce_sample = 1'b1;
    step(1);
    ce_sample = 1'b0;
    step(4);
    @(negedge clk_sys);
    chk({name, "_early"}, out_valid, 1'b0);
    step(1);
    @(negedge clk_sys);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_l"}, out_l, el);
    chk({name, "_r"}, out_r, er);
    chk({name, "_clip"}, clip, ec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected done by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("rst_out_l", out_l, 16'h0);
    chk("rst_out_r", out_r, 16'h0);
    chk("rst_flags", {out_valid, busy, clip, overrun}, 4'b0000);
    chk("rst_clip_cnt", clip_cnt, 16'h0);

    // Unity pass-through; ch1 muted by zero gain, ch2 has no enables.
    set_ch(0, 16'h4000, 8'h80, 1, 1);
    set_ch(1, 16'hFFFF, 8'h00, 1, 1);
    set_ch(2, 16'hFFFF, 8'hFF, 0, 0);
    set_ch(3, 16'h0000, 8'h00, 0, 0);
    run_mix("unity", 16'h4000, 16'h4000, 1'b0);
    step(1);

    // Half gain with truncation, left only.
    set_ch(0, 16'h0000, 8'h00, 0, 0);
    set_ch(1, 16'h1235, 8'h40, 1, 0);
    run_mix("half", 16'h091A, 16'h0000, 1'b0);
    step(2);
    chk("hold_l", out_l, 16'h091A);

    // Saturation, twice.
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 16'h8000, 8'h80, 1, 1);
    run_mix("sat1", 16'hFFFF, 16'hFFFF, 1'b1);
    step(2);
`ifdef AUDIO_MIX_CLIP_CNT_EN
    chk("clip_cnt_1", clip_cnt, 16'd1);
`else
    chk("clip_cnt_1", clip_cnt, 16'd0);
`endif
    run_mix("sat2", 16'hFFFF, 16'hFFFF, 1'b1);
    step(2);
`ifdef AUDIO_MIX_CLIP_CNT_EN
    chk("clip_cnt_2", clip_cnt, 16'd2);
`else
    chk("clip_cnt_2", clip_cnt, 16'd0);
`endif
    clip_cnt_clr = 1'b1;
    step(1);
    clip_cnt_clr = 1'b0;
    @(negedge clk_sys);
    chk("clip_cnt_clr", clip_cnt, 16'd0);

    // Snapshot isolation and dropped strobe.
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 16'h0000, 8'h00, 0, 0);
    set_ch(0, 16'h1000, 8'h80, 1, 0);
    step(1);
    ce_sample = 1'b1;
    step(1);
    ce_sample = 1'b0;
    step(1);
    ch_in[0] = 16'h7000;
    step(1);
    ce_sample = 1'b1;
    step(1);
    ce_sample = 1'b0;
    @(negedge clk_sys);
    chk("ovr_set", overrun, 1'b1);
    step(2);
    @(negedge clk_sys);
    chk("snap_valid", out_valid, 1'b1);
    chk("snap_l", out_l, 16'h1000);
    chk("snap_r", out_r, 16'h0000);
    step(3);
    @(negedge clk_sys);
    chk("ovr_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    @(negedge clk_sys);
    chk("ovr_clr", overrun, 1'b0);

    // Drop and clear in the same cycle: the drop wins.
    ce_sample = 1'b1;
    step(1);
    overrun_clr = 1'b1;
    step(1);
    ce_sample = 1'b0;
    overrun_clr = 1'b0;
    @(negedge clk_sys);
    chk("ovr_set_wins", overrun, 1'b1);
    step(6);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;

    // Reset mid-mix aborts the sample.
    set_ch(0, 16'h2000, 8'h80, 1, 1);
    ce_sample = 1'b1;
    step(1);
    ce_sample = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("abort_out_l", out_l, 16'h0);
    chk("abort_flags", {busy, clip, overrun}, 3'b000);
    step(2);
    @(negedge clk_sys);
    chk("abort_no_valid", out_valid, 1'b0);
    step(1);
    run_mix("post_rst", 16'h2000, 16'h2000, 1'b0);

    // Back-to-back strobes at minimum spacing.
    step(1);
    set_ch(1, 16'h0100, 8'hC0, 0, 1);
    run_mix("b2b_a", 16'h2000, 16'h2180, 1'b0);
    set_ch(0, 16'h0000, 8'h00, 0, 0);
    run_mix("b2b_b", 16'h0000, 16'h0180, 1'b0);
    chk("b2b_ovr", overrun, 1'b0);

    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
